lzrw1_decompressor: RTL and testbench
=====================================

LZRW1_DECOMPRESSOR -- requirements
Module: lzrw1_decompressor

Interface
REQ-001 Parameter: WINDOW_SIZE, default 4096, history window depth in bytes; the offset width is 12 bits.
REQ-002 Ports:
- clock  in  1  clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous, active-high.
REQ-003 Ports:
- in_valid  in  1  item present.
- in_ready  out  1  item accepted when in_valid && in_ready.
REQ-004 Ports:
- in_ctrl  in  1  0 = literal, 1 = copy.
- in_literal  in  8  literal byte, used when in_ctrl=0.
REQ-005 Ports:
- in_offset  in  12  copy distance back from the next output position.
- in_length  in  4  copy length in bytes.
REQ-006 Ports:
- out_valid  out  1  output byte present.
- out_ready  in  1  byte consumed when out_valid && out_ready.
REQ-007 Ports:
- out_byte  out  8  decompressed byte.
- out_pos  out  32  stream index of out_byte.
- error  out  1  sticky illegal-item flag.

Function
REQ-008 The block SHALL keep a WINDOW_SIZE x 8 history buffer, written at index wr_pos[11:0] for every byte loaded into the output register, where wr_pos is a 32-bit count of bytes produced that wraps at 2^32.
REQ-009 The output register SHALL load when it is free, meaning (!out_valid || out_ready); out_valid, out_byte and out_pos SHALL hold while out_valid && !out_ready.
REQ-010 States:
- IDLE: in_ready = output register free.
- COPY: in_ready = 0.
REQ-011 A literal accepted in cycle N SHALL give out_byte = in_literal with out_valid=1 in cycle N+1 and out_pos = wr_pos at acceptance; the state SHALL remain IDLE.
REQ-012 A legal copy accepted in cycle N SHALL go to COPY with remaining = in_length and rd_pos = wr_pos - in_offset (12-bit wrap); one byte SHALL be emitted per free cycle from history[rd_pos], with rd_pos and wr_pos incremented and remaining decremented for each byte.
REQ-013 With out_ready held at 1, a copy of length L SHALL produce bytes in cycles N+1..N+L; in_ready SHALL return to 1 in the cycle the last byte loads, so back-to-back items leave no bubble.
REQ-014 Overlapping copies (offset < length) SHALL repeat the pattern byte-wise, e.g. offset 1 replicates the last byte; the read address is always strictly older than the write address.
REQ-015 A copy is legal when:
- 3 <= in_length <= 15;
- in_offset != 0;
- in_offset <= wr_pos, or wr_pos >= WINDOW_SIZE.
REQ-016 An illegal copy SHALL be consumed with no output byte, set error=1, and the block SHALL stay in IDLE.
REQ-017 Once set, error SHALL be cleared only by reset; processing of later items SHALL continue normally.
REQ-018 wr_pos wrapping 0xFFFFFFFF->0 SHALL NOT affect legality; the window-full condition is held by a sticky "window filled" flag.

Reset
REQ-019 While reset=1:
- state=IDLE; in_ready=0; out_valid=0.
- out_byte=0; out_pos=0; error=0.
- wr_pos=0; remaining=0; window-filled flag=0.
- all history bytes = 0.
REQ-020 Reset asserted during COPY SHALL abort the copy in the same edge; no partial byte is emitted afterwards.
REQ-021 in_ready SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-022 With LZRW1_DECOMP_CHECK_EN defined, the legality checks of REQ-015..REQ-018 SHALL be implemented.
REQ-023 Without LZRW1_DECOMP_CHECK_EN, error SHALL be tied to 0 and every copy SHALL be executed as given:
- length 0 is consumed with no output;
- lengths 1..2 emit 1..2 bytes;
- offset 0 reads history[wr_pos[11:0]], i.e. stale data.

Structure
REQ-024 Package lzrw1_pkg SHALL hold:
- WINDOW_SIZE, OFFSET_W=12, LEN_W=4, MIN_MATCH=3;
- the state enum {IDLE, COPY};
- an item struct {ctrl, literal, offset, length};
- these SHALL be shared with the compressor side.
REQ-025 Sub-module lzrw1_history_buf SHALL contain the history storage: one write port, one combinational read port, and synchronous clear on reset.

Verification
REQ-026 Literals 0x41, 0x42, 0x43 with out_ready=1 -> bytes 41, 42, 43 at out_pos 0, 1, 2, each one cycle after acceptance.
REQ-027 After literals "ABCD", copy offset=4, length=4 -> ABCD, in consecutive cycles with in_ready=0 for 3 cycles.
REQ-028 After literal 0x5A, copy offset=1, length=15 -> 15 bytes of 5A; total wr_pos=16.
REQ-029 During a copy of length 6, out_ready=0 for 3 cycles mid-copy -> out_byte and out_pos held, no byte lost or duplicated.
REQ-030 With CHECK_EN, copy offset=5 at wr_pos=2, then copy length=2 -> error=1, no output; a following literal 0x11 is still emitted.
REQ-031 Reset asserted on the third byte of a length-8 copy -> out_valid=0, wr_pos=0 and history zero the next cycle, and no further bytes are emitted.

Source files
------------

// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 definitions: window geometry, decoder states and the item format
// exchanged between the compressor and decompressor.
package lzrw1_pkg;

  localparam int WINDOW_SIZE = 4096;
  localparam int OFFSET_W    = 12;
  localparam int LEN_W       = 4;
  localparam int MIN_MATCH   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } state_e;

  typedef struct packed {
    logic                ctrl;
    logic [7:0]          literal;
    logic [OFFSET_W-1:0] offset;
    logic [LEN_W-1:0]    length;
  } item_t;

endpackage

// File: rtl/lzrw1_decompressor_if.sv
// Item input and byte output handshake bundle of the LZRW1 decompressor.
interface lzrw1_decompressor_if;
  import lzrw1_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_ctrl;
  logic [7:0]          in_literal;
  logic [OFFSET_W-1:0] in_offset;
  logic [LEN_W-1:0]    in_length;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_byte;
  logic [31:0]         out_pos;
  logic                error;

  modport master (
    output in_valid, in_ctrl, in_literal, in_offset, in_length, out_ready,
    input  in_ready, out_valid, out_byte, out_pos, error
  );

  modport slave (
    input  in_valid, in_ctrl, in_literal, in_offset, in_length, out_ready,
    output in_ready, out_valid, out_byte, out_pos, error
  );

endinterface

// File: rtl/lzrw1_history_buf.sv
// History window: one write port, one combinational read port, cleared to zero
// while reset is high.
module lzrw1_history_buf #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lzrw1_decompressor.sv
// LZRW1 item decoder: literals and back-references in, one byte per free cycle out.
// Define LZRW1_DECOMP_CHECK_EN to reject illegal copies and raise the sticky error flag.
module lzrw1_decompressor #(
  parameter int WINDOW_SIZE = lzrw1_pkg::WINDOW_SIZE
) (
  input logic                  clock,
  input logic                  reset,
  lzrw1_decompressor_if.slave  bus
);
  import lzrw1_pkg::*;

  state_e              state_q, state_d;
  logic [31:0]         wr_pos_q, wr_pos_d;
  logic [31:0]         out_pos_q, out_pos_d;
  logic [OFFSET_W-1:0] rd_pos_q, rd_pos_d, raddr;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_byte_q, out_byte_d;
  logic [7:0]          rdata, emit_byte;
  logic                out_free, accept, copy_ok, emit;
  item_t               item;

  assign item     = '{ctrl: bus.in_ctrl, literal: bus.in_literal,
                      offset: bus.in_offset, length: bus.in_length};
  assign out_free = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (state_q == IDLE) && out_free && !reset;
  assign accept   = bus.in_valid && bus.in_ready;
  // The first copy byte is read in the accept cycle so a copy has literal latency.
  assign raddr    = (state_q == COPY) ? rd_pos_q : (wr_pos_q[OFFSET_W-1:0] - item.offset);

`ifdef LZRW1_DECOMP_CHECK_EN
  logic error_q, error_d, filled_q, filled_d;

  // filled_q remembers a full window so wr_pos wrapping cannot re-enable the offset check.
  assign copy_ok  = (item.length >= LEN_W'(MIN_MATCH)) && (item.offset != '0) &&
                    (({{(32-OFFSET_W){1'b0}}, item.offset} <= wr_pos_q) ||
                     (wr_pos_q >= 32'(WINDOW_SIZE)) || filled_q);
  assign error_d  = error_q || (accept && item.ctrl && !copy_ok);
  assign filled_d = filled_q || (wr_pos_q >= 32'(WINDOW_SIZE));

  always_ff @(posedge clock) begin
    if (reset) begin
      error_q  <= 1'b0;
      filled_q <= 1'b0;
    end else begin
      error_q  <= error_d;
      filled_q <= filled_d;
    end
  end

  assign bus.error = error_q;
`else
  assign copy_ok   = 1'b1;
  assign bus.error = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_pos_d    = wr_pos_q;
    rd_pos_d    = rd_pos_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_byte_d  = out_byte_q;
    out_pos_d   = out_pos_q;
    emit        = 1'b0;
    emit_byte   = rdata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!item.ctrl) begin
            emit      = 1'b1;
            emit_byte = item.literal;
          end else if (copy_ok && (item.length != '0)) begin
            emit        = 1'b1;
            rd_pos_d    = raddr + OFFSET_W'(1);
            remaining_d = item.length - LEN_W'(1);
            if (item.length != LEN_W'(1)) state_d = COPY;
          end
        end
      end
      COPY: begin
        if (out_free) begin
          emit        = 1'b1;
          rd_pos_d    = rd_pos_q + OFFSET_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      out_valid_d = 1'b1;
      out_byte_d  = emit_byte;
      out_pos_d   = wr_pos_q;
      wr_pos_d    = wr_pos_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_pos_q    <= '0;
      rd_pos_q    <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_pos_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_pos_q    <= wr_pos_d;
      rd_pos_q    <= rd_pos_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_pos_q   <= out_pos_d;
    end
  end

  lzrw1_history_buf #(.DEPTH(WINDOW_SIZE), .AW(OFFSET_W)) u_hist (
    .clock   (clock),
    .reset   (reset),
    .we_i    (emit),
    .waddr_i (wr_pos_q[OFFSET_W-1:0]),
    .wdata_i (emit_byte),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_pos   = out_pos_q;

endmodule

// File: tb/tb_lzrw1_decompressor.sv
// Bench for lzrw1_decompressor: directed scenarios plus random items, with a
// byte-stream reference model feeding a scoreboard checked by an output monitor.
module tb_lzrw1_decompressor;

  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] p;
  } exp_t;

  logic clock;
  logic reset;
  lzrw1_decompressor_if bus();

  lzrw1_decompressor dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [7:0]  m_hist [4096];
  logic [31:0] m_wr;
  logic        m_err;
  logic        m_filled;
  logic [31:0] last_pos;
  bit          rnd_ready = 0;
  int          stall_total = 0;

  logic        r_c;
  logic [7:0]  r_lit;
  logic [11:0] r_off;
  logic [3:0]  r_len;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic put(input logic [7:0] b);
    exp_t e;
    e.b = b;
    e.p = m_wr;
    exp_q.push_back(e);
    m_hist[m_wr[11:0]] = b;
    m_wr = m_wr + 1;
    if (m_wr >= 4096) m_filled = 1'b1;
  endtask

  // Reference: each copied byte is the stream byte `off` positions behind the current end.
  task automatic model(input logic c, input logic [7:0] lit, input logic [11:0] off,
                       input logic [3:0] len);
    logic [11:0] src;
    if (!c) begin
      put(lit);
      return;
    end
`ifdef LZRW1_DECOMP_CHECK_EN
    if (len < 3 || off == 0 || ({20'b0, off} > m_wr && !m_filled)) begin
      m_err = 1'b1;
      return;
    end
`endif
    for (int k = 0; k < int'(len); k++) begin
      src = m_wr[11:0] - off;
      put(m_hist[src]);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the item.
  task automatic send(input logic c, input logic [7:0] lit, input logic [11:0] off,
                      input logic [3:0] len);
    int n = 0;
    bit ok = 0;
    bus.in_valid   = 1'b1;
    bus.in_ctrl    = c;
    bus.in_literal = lit;
    bus.in_offset  = off;
    bus.in_length  = len;
    while (!ok && n < 500) begin
      @(negedge clock);
      if (bus.in_ready) ok = 1;
      else n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=0 expected=1 at %0t", $time);
    end else begin
      model(c, lit, off, len);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
    end
    repeat (4) @(negedge clock);
    chk("error_flag", bus.error, m_err);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    m_wr = 0;
    m_err = 1'b0;
    m_filled = 1'b0;
    for (int i = 0; i < 4096; i++) m_hist[i] = 8'h00;
    @(negedge clock);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_byte", bus.out_byte, 0);
    chk("rst_out_pos", bus.out_pos, 0);
    chk("rst_error", bus.error, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clock);
    #1;
  endtask

  // Output ready driver: forced stalls first, then random or always-ready.
  initial begin
    int served = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (served < stall_total) begin
        bus.out_ready = 1'b0;
        served++;
      end else if (rnd_ready) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stalled outputs hold.
  initial begin
    exp_t       e;
    bit         hold_chk = 0;
    logic [7:0] hold_b = '0;
    logic [31:0] hold_p = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_chk = 0;
      end else begin
        if (hold_chk) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_byte", bus.out_byte, hold_b);
          chk("hold_pos", bus.out_pos, hold_p);
        end
        hold_chk = bus.out_valid && !bus.out_ready;
        hold_b   = bus.out_byte;
        hold_p   = bus.out_pos;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte actual=%0h pos=%0d expected=none", bus.out_byte, bus.out_pos);
          end else begin
            e = exp_q.pop_front();
            chk("out_byte", bus.out_byte, e.b);
            chk("out_pos", bus.out_pos, e.p);
            last_pos = bus.out_pos;
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_ctrl = 1'b0;
    bus.in_literal = '0;
    bus.in_offset = '0;
    bus.in_length = '0;
    last_pos = '0;

    // Literals, including one-cycle latency
    do_reset();
    send(1'b0, 8'h41, 12'd0, 4'd0);
    @(negedge clock);
    chk("lit_latency_valid", bus.out_valid, 1);
    chk("lit_latency_byte", bus.out_byte, 8'h41);
    @(posedge clock);
    #1;
    send(1'b0, 8'h42, 12'd0, 4'd0);
    send(1'b0, 8'h43, 12'd0, 4'd0);
    drain();
    chk("lit_last_pos", last_pos, 2);

    // Non-overlapping copy: in_ready low for exactly three cycles
    do_reset();
    send(1'b0, 8'h41, 12'd0, 4'd0);
    send(1'b0, 8'h42, 12'd0, 4'd0);
    send(1'b0, 8'h43, 12'd0, 4'd0);
    send(1'b0, 8'h44, 12'd0, 4'd0);
    send(1'b1, 8'h00, 12'd4, 4'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("copy_busy_in_ready", bus.in_ready, 0);
    end
    @(negedge clock);
    chk("copy_done_in_ready", bus.in_ready, 1);
    @(posedge clock);
    #1;
    drain();
    chk("copy_last_pos", last_pos, 7);

    // Run-length style overlapping copy
    do_reset();
    send(1'b0, 8'h5A, 12'd0, 4'd0);
    send(1'b1, 8'h00, 12'd1, 4'd15);
    drain();
    chk("rle_last_pos", last_pos, 15);

    // Output stall in the middle of a copy
    do_reset();
    for (int i = 0; i < 6; i++) send(1'b0, 8'(8'h10 + i), 12'd0, 4'd0);
    send(1'b1, 8'h00, 12'd6, 4'd6);
    @(negedge clock);
    stall_total = stall_total + 3;
    @(posedge clock);
    #1;
    drain();
    chk("stall_last_pos", last_pos, 11);

`ifdef LZRW1_DECOMP_CHECK_EN
    // Illegal copies are dropped, error sticks, later items still decode
    do_reset();
    send(1'b0, 8'h01, 12'd0, 4'd0);
    send(1'b0, 8'h02, 12'd0, 4'd0);
    send(1'b1, 8'h00, 12'd5, 4'd3);
    drain();
    send(1'b1, 8'h00, 12'd1, 4'd2);
    send(1'b0, 8'h11, 12'd0, 4'd0);
    drain();
    chk("illegal_last_pos", last_pos, 2);
`else
    // Unchecked copies: length 0 is dropped, short lengths emitted, offset 0 reads stale data
    do_reset();
    send(1'b0, 8'h07, 12'd0, 4'd0);
    send(1'b1, 8'h00, 12'd1, 4'd0);
    send(1'b1, 8'h00, 12'd1, 4'd2);
    send(1'b1, 8'h00, 12'd0, 4'd3);
    drain();
    chk("unchecked_last_pos", last_pos, 5);
`endif

    // Reset during the third byte of a length-8 copy
    do_reset();
    for (int i = 0; i < 8; i++) send(1'b0, 8'(8'hA0 + i), 12'd0, 4'd0);
    send(1'b1, 8'h00, 12'd8, 4'd8);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    do_reset();
`ifdef LZRW1_DECOMP_CHECK_EN
    send(1'b0, 8'h33, 12'd0, 4'd0);
    send(1'b1, 8'h00, 12'd1, 4'd3);
`else
    send(1'b1, 8'h00, 12'd0, 4'd3);
`endif
    drain();
    chk("post_abort_last_pos", last_pos, 
`ifdef LZRW1_DECOMP_CHECK_EN
        3
`else
        2
`endif
    );

    // Random items with random output backpressure
    do_reset();
    rnd_ready = 1;
    for (int i = 0; i < 1200; i++) begin
      r_c   = ($urandom_range(0, 9) < 4);
      r_lit = 8'($urandom);
      r_off = ($urandom_range(0, 3) != 0) ? 12'($urandom_range(0, 24)) : 12'($urandom);
      r_len = 4'($urandom);
      send(r_c, r_lit, r_off, r_len);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clock);
        #1;
      end
    end
    drain();
    rnd_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
